// File: rtl/aes_block_sequencer.sv
// Job-level sequencer for a shared AES-128 core: key once per job, one block at a time, CBC chaining.
// Build option: define AES_SEQ_CBC_EN for CBC; leave it undefined for ECB (no chain register).
module aes_block_sequencer #(
    parameter int unsigned  CNT_W      = 16,
    parameter logic [127:0] IV_DEFAULT = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             iv_load_i,
    input  logic [127:0]     iv_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic [127:0]     word_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [127:0]     key_i,
    output logic             aes_ld_o,
    output logic [127:0]     aes_text_o,
    output logic [127:0]     aes_key_o,
    input  logic             aes_done_i,
    input  logic [127:0]     aes_out_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o,
    output logic [2:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A source holds valid and data stable until that transfer; ready never looks at the same
    // interface's valid (word_ready may look at key_valid so key and block 0 can move together).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_key;
    logic               r_key_valid;
    logic [127:0]       r_aes_text;
    logic [127:0]       r_aes_key;
    logic               r_aes_ld;
    logic [127:0]       r_out_data;
    logic               r_out_valid;
    logic               r_done;
    logic               r_err;

    logic [127:0]       w_chain;
    logic               w_key_hs;
    logic               w_word_hs;
    logic [CNT_W-1:0]   w_cnt_next;

`ifdef AES_SEQ_CBC_EN
    logic [127:0]       r_chain;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_chain <= IV_DEFAULT;
        end else if (r_state == S_IDLE && start_i && iv_load_i) begin
            r_chain <= iv_i;
        end else if (r_state == S_RUN && aes_done_i) begin
            r_chain <= aes_out_i;
        end
    end

    assign w_chain = r_chain;
`else
    logic w_unused;
    assign w_unused = ^{iv_load_i, iv_i, IV_DEFAULT};
    assign w_chain  = '0;
`endif

    // Key is requested only while no key is held, i.e. for block 0 of each job.
    assign key_ready_o  = (r_state == S_FETCH) && !r_key_valid;
    assign word_ready_o = (r_state == S_FETCH) && (r_key_valid || key_valid_i);
    assign w_key_hs     = key_ready_o && key_valid_i;
    assign w_word_hs    = word_ready_o && word_valid_i;
    assign w_cnt_next   = r_cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_aes_text  <= '0;
            r_aes_key   <= '0;
            r_aes_ld    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_aes_ld <= 1'b0;
            r_done   <= 1'b0;
            if (aes_done_i && r_state != S_RUN) begin
                r_err <= 1'b1;
            end
            if (w_key_hs) begin
                r_key       <= key_i;
                r_key_valid <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len       <= len_i;
                        r_cnt       <= '0;
                        r_key_valid <= 1'b0;
                        if (len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_word_hs) begin
                        r_aes_text <= word_i ^ w_chain;
                        r_aes_key  <= r_key_valid ? r_key : key_i;
                        r_aes_ld   <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (aes_done_i) begin
                        r_out_data  <= aes_out_i;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign aes_ld_o    = r_aes_ld;
    assign aes_text_o  = r_aes_text;
    assign aes_key_o   = r_aes_key;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign cnt_o       = r_cnt;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: acts as the cipher core and checks every ciphertext beat against a queue.
// Works for both builds (AES_SEQ_CBC_EN defined or not).
module tb_aes_block_sequencer;

    localparam int CNT_W = 16;
    localparam logic [127:0] IV_DEF = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst, clear, start, iv_load;
    logic [CNT_W-1:0] len;
    logic [127:0]     iv, word, key, aes_out, aes_text, aes_key, out_data;
    logic             word_valid, word_ready, key_valid, key_ready;
    logic             aes_ld, aes_done, out_valid, out_ready, busy, done, err;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dbg_state;

    int total = 0;
    int bad   = 0;
    int ld_cnt = 0, done_cnt = 0, key_hs_cnt = 0, out_cnt = 0;
    bit busy_seen = 1'b0;
    int core_lat = 2;
    logic [127:0] m_chain = IV_DEF;
    logic [127:0] exp_q[$];
    logic [127:0] text_q[$];
    logic [127:0] key_q[$];
    logic [127:0] got_q[$];

    aes_block_sequencer dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .len_i(len),
        .iv_load_i(iv_load), .iv_i(iv),
        .word_valid_i(word_valid), .word_ready_o(word_ready), .word_i(word),
        .key_valid_i(key_valid), .key_ready_o(key_ready), .key_i(key),
        .aes_ld_o(aes_ld), .aes_text_o(aes_text), .aes_key_o(aes_key),
        .aes_done_i(aes_done), .aes_out_i(aes_out),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .done_o(done), .cnt_o(cnt), .err_o(err), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Stand-in cipher: the FIPS-197 vector for its key/plaintext, a cheap mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == P0 && k == K0) return FIPS_CT;
        return {t[95:0], t[127:96]} ^ k ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_99999999;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---- scoreboard model ----
    task automatic model_start(input logic ivl, input logic [127:0] v);
`ifdef AES_SEQ_CBC_EN
        if (ivl) m_chain = v;
`endif
    endtask

    task automatic model_block(input logic [127:0] pt, input logic [127:0] k, input bit push_ct);
        logic [127:0] t, ct;
`ifdef AES_SEQ_CBC_EN
        t = pt ^ m_chain;
`else
        t = pt;
`endif
        text_q.push_back(t);
        key_q.push_back(k);
        if (push_ct) begin
            ct = core_fn(t, k);
            exp_q.push_back(ct);
            m_chain = ct;
        end
    endtask

    // ---- core stub ----
    initial begin
        logic [127:0] cap_t, cap_k;
        aes_done = 1'b0;
        aes_out  = '0;
        forever begin
            @(negedge clk);
            if (aes_ld) begin
                cap_t = aes_text;
                cap_k = aes_key;
                repeat (core_lat) @(posedge clk);
                #1;
                aes_done = 1'b1;
                aes_out  = core_fn(cap_t, cap_k);
                @(posedge clk);
                #1;
                aes_done = 1'b0;
            end
        end
    end

    // ---- monitor ----
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (aes_ld) begin
                    ld_cnt++;
                    if (text_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ld_unexpected: got text %h want no load", aes_text);
                    end else begin
                        chk("aes_text", aes_text, text_q.pop_front());
                        chk("aes_key", aes_key, key_q.pop_front());
                    end
                end
                if (done) done_cnt++;
                if (key_valid && key_ready) key_hs_cnt++;
                if (busy) busy_seen = 1'b1;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    got_q.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL out_unexpected: got %h want no beat", out_data);
                    end else begin
                        chk("out_data", out_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---- drivers ----
    task automatic start_job(input logic [CNT_W-1:0] n, input logic ivl, input logic [127:0] v);
        @(posedge clk); #1;
        start = 1'b1; len = n; iv_load = ivl; iv = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, input bit give_key, input logic [127:0] k);
        bit kdone, wdone;
        int t;
        @(posedge clk); #1;
        word = pt;
        word_valid = 1'b1;
        if (give_key) begin
            key = k;
            key_valid = 1'b1;
        end
        kdone = !give_key;
        wdone = 1'b0;
        t = 0;
        while (!(kdone && wdone) && t < 300) begin
            @(negedge clk);
            if (key_valid && key_ready) kdone = 1'b1;
            if (word_valid && word_ready) wdone = 1'b1;
            @(posedge clk); #1;
            if (kdone) key_valid = 1'b0;
            if (wdone) word_valid = 1'b0;
            t++;
        end
        chk("send_handshake", {126'd0, kdone, wdone}, 128'd3);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {127'd0, seen}, 128'd1);
        @(negedge clk);
        chk({name, "_pulse_end"}, {127'd0, done}, 128'd0);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (dbg_state == s) seen = 1'b1;
        end
        chk(name, {127'd0, seen}, 128'd1);
    endtask

    initial begin
        int ld0, dn0, kh0, oc0, g0, stall_bad;
        bit seen;
        rst = 1'b1; clear = 1'b0; start = 1'b0; len = '0; iv_load = 1'b0; iv = '0;
        word_valid = 1'b0; word = '0; key_valid = 1'b0; key = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_outs", {122'd0, done, aes_ld, out_valid, err, key_ready, word_ready}, 128'd0);
        chk("rst_text", aes_text, 128'd0);
        chk("rst_key", aes_key, 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_cnt", {112'd0, cnt}, 128'd0);

        // single block, FIPS-197 vector
        ld0 = ld_cnt; dn0 = done_cnt; kh0 = key_hs_cnt;
        model_start(1'b1, 128'd0);
        start_job(16'd1, 1'b1, 128'd0);
        @(negedge clk);
        chk("a_fetch_next_cycle", {125'd0, dbg_state}, 128'd1);
        model_block(P0, K0, 1'b1);
        send_block(P0, 1'b1, K0);
        wait_done("a_done");
        chk("a_fips_ct", got_q[got_q.size()-1], FIPS_CT);
        chk("a_ld_count", 128'(ld_cnt - ld0), 128'd1);
        chk("a_done_count", 128'(done_cnt - dn0), 128'd1);
        chk("a_key_hs", 128'(key_hs_cnt - kh0), 128'd1);
        chk("a_cnt", {112'd0, cnt}, 128'd1);
        chk("a_idle", {127'd0, busy}, 128'd0);

        // three blocks, fresh IV
        core_lat = 3;
        kh0 = key_hs_cnt; oc0 = out_cnt; ld0 = ld_cnt;
        model_start(1'b1, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
        start_job(16'd3, 1'b1, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
        model_block(128'h11111111222222223333333344444444, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        send_block(128'h11111111222222223333333344444444, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        model_block(128'hdeadbeef00000000cafef00d12345678, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        send_block(128'hdeadbeef00000000cafef00d12345678, 1'b0, '0);
        model_block(128'h0123456789abcdeffedcba9876543210, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        send_block(128'h0123456789abcdeffedcba9876543210, 1'b0, '0);
        wait_done("b_done");
        chk("b_key_hs", 128'(key_hs_cnt - kh0), 128'd1);
        chk("b_beats", 128'(out_cnt - oc0), 128'd3);
        chk("b_ld_count", 128'(ld_cnt - ld0), 128'd3);
        chk("b_cnt", {112'd0, cnt}, 128'd3);

        // backpressure, chaining from previous job (iv_load = 0)
        core_lat = 2;
        out_ready = 1'b0;
        ld0 = ld_cnt;
        start_job(16'd2, 1'b0, 128'h99999999999999999999999999999999);
        model_block(128'haaaa0000bbbb1111cccc2222dddd3333, 128'h3c4fcf098815f7aba6d2ae2816157e2b, 1'b1);
        send_block(128'haaaa0000bbbb1111cccc2222dddd3333, 1'b1, 128'h3c4fcf098815f7aba6d2ae2816157e2b);
        model_block(128'h5555666677778888999900001111aaaa, 128'h3c4fcf098815f7aba6d2ae2816157e2b, 1'b1);
        @(posedge clk); #1;
        word = 128'h5555666677778888999900001111aaaa;
        word_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("c_out_valid", {127'd0, seen}, 128'd1);
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (exp_q.size() > 0) chk("c_data_stable", out_data, exp_q[0]);
            if (word_ready || aes_ld || !out_valid) stall_bad++;
        end
        chk("c_stall_ctrl", 128'(stall_bad), 128'd0);
        chk("c_ld_during_stall", 128'(ld_cnt - ld0), 128'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_block(128'h5555666677778888999900001111aaaa, 1'b0, '0);
        wait_done("c_done");
        chk("c_cnt", {112'd0, cnt}, 128'd2);

        // zero-length job applies IV, never goes busy
        ld0 = ld_cnt;
        busy_seen = 1'b0;
        model_start(1'b1, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f);
        start_job(16'd0, 1'b1, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f);
        @(negedge clk);
        chk("d_done_next", {127'd0, done}, 128'd1);
        @(negedge clk);
        chk("d_done_single", {127'd0, done}, 128'd0);
        repeat (4) @(negedge clk);
        chk("d_no_busy", {127'd0, busy_seen}, 128'd0);
        chk("d_no_ld", 128'(ld_cnt - ld0), 128'd0);

        // start during RUN is ignored
        core_lat = 8;
        start_job(16'd2, 1'b0, '0);
        model_block(128'h13579bdf02468ace13579bdf02468ace, 128'h00000000000000000000000000000001, 1'b1);
        send_block(128'h13579bdf02468ace13579bdf02468ace, 1'b1, 128'h00000000000000000000000000000001);
        wait_state(3'd3, "e_reach_run");
        start_job(16'd5, 1'b1, 128'hffffffffffffffffffffffffffffffff);
        @(negedge clk);
        chk("e_still_run", {125'd0, dbg_state}, 128'd3);
        chk("e_cnt_kept", {112'd0, cnt}, 128'd0);
        model_block(128'hfedcba9876543210fedcba9876543210, 128'h00000000000000000000000000000001, 1'b1);
        send_block(128'hfedcba9876543210fedcba9876543210, 1'b0, '0);
        wait_done("e_done");
        chk("e_cnt", {112'd0, cnt}, 128'd2);

        // clear during RUN, late core result sets err
        core_lat = 6;
        chk("f_err_before", {127'd0, err}, 128'd0);
        start_job(16'd1, 1'b1, 128'h77777777777777777777777777777777);
        model_start(1'b1, 128'h77777777777777777777777777777777);
        model_block(128'h0badc0de0badc0de0badc0de0badc0de, K0, 1'b0);
        send_block(128'h0badc0de0badc0de0badc0de0badc0de, 1'b1, K0);
        wait_state(3'd3, "f_reach_run");
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        m_chain = IV_DEF;
        @(negedge clk);
        chk("f_idle", {125'd0, dbg_state}, 128'd0);
        chk("f_text_zero", aes_text, 128'd0);
        chk("f_key_zero", aes_key, 128'd0);
        chk("f_data_zero", out_data, 128'd0);
        chk("f_flags_zero", {124'd0, busy, out_valid, done, err}, 128'd0);
        chk("f_cnt_zero", {112'd0, cnt}, 128'd0);
        repeat (8) @(negedge clk);
        chk("f_err_late", {127'd0, err}, 128'd1);
        chk("f_no_out", {127'd0, out_valid}, 128'd0);

        // after clear the chain restarts from IV_DEFAULT
        core_lat = 1;
        start_job(16'd1, 1'b0, 128'h12121212121212121212121212121212);
        model_block(128'h00000000000000000000000000000000, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        send_block(128'h00000000000000000000000000000000, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done("g_done");
        chk("g_err_sticky", {127'd0, err}, 128'd1);
        chk("g_cnt", {112'd0, cnt}, 128'd1);

        // identical plaintext twice
        g0 = got_q.size();
        model_start(1'b1, 128'h31415926535897932384626433832795);
        start_job(16'd2, 1'b1, 128'h31415926535897932384626433832795);
        model_block(128'h42424242424242424242424242424242, K0, 1'b1);
        send_block(128'h42424242424242424242424242424242, 1'b1, K0);
        model_block(128'h42424242424242424242424242424242, K0, 1'b1);
        send_block(128'h42424242424242424242424242424242, 1'b0, '0);
        wait_done("h_done");
        chk("h_beats", 128'(got_q.size() - g0), 128'd2);
        if (got_q.size() >= g0 + 2) begin
`ifdef AES_SEQ_CBC_EN
            chk("h_cbc_differ", {127'd0, got_q[g0] != got_q[g0+1]}, 128'd1);
`else
            chk("h_ecb_same", {127'd0, got_q[g0] == got_q[g0+1]}, 128'd1);
`endif
        end

        repeat (5) @(negedge clk);
        chk("end_exp_q_empty", 128'(exp_q.size()), 128'd0);
        chk("end_text_q_empty", 128'(text_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
